// File: rtl/event_timestamper_if.sv
// Output stream of the event timestamper: FIFO head plus valid/ready handshake.
// The master drives the head entry; the slave (consumer) drives out_ready.
interface event_timestamper_if;
  logic [15:0] out_data;
  logic        out_first;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output out_data,
    output out_first,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_first,
    input  out_valid,
    output out_ready
  );
endinterface : event_timestamper_if

// File: rtl/event_timestamper.sv
// Event timestamper: detects rising edges on event_in, strobes the 100 us
// timer, captures its count, and queues the event-to-event delta (plus a
// first-event flag) in a small FIFO for a downstream consumer.
module event_timestamper #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   event_in,
  input  logic [15:0]            timer_count,
  output logic                   timer_read,
  output logic [AW:0]            fill,
  output logic                   overflow,
  output logic                   dropped,
  input  logic                   clear_flags,
  event_timestamper_if.master    out_if
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    CAPTURE = 2'd2
  } state_e;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  // Control state
  state_e        state_q;
  logic          ev_q;
  logic          armed_q;
  logic          pending_q;
  logic          first_done_q;
  logic          timer_read_q;
  logic [15:0]   prev_ts_q;
  logic          overflow_q;
  logic          dropped_q;

  // FIFO state
  logic [16:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;

  // Combinational decode
  logic          edge_d;
  logic          push_d;
  logic          pop_d;
  logic          full_d;
  logic          wr_en_d;
  logic          ovf_set_d;
  logic          drop_set_d;
  logic [16:0]   entry_d;

  // Edge detection, FIFO push/pop qualification and the entry to be written.
  always_comb begin
    // NOTE: every signal assigned here gets a value on every path; a missing
    // default in always_comb would infer a latch.
    edge_d     = 1'b0;
    push_d     = 1'b0;
    pop_d      = 1'b0;
    full_d     = 1'b0;
    wr_en_d    = 1'b0;
    ovf_set_d  = 1'b0;
    drop_set_d = 1'b0;
    entry_d    = {1'b1, 16'h0000};

    // armed_q masks the first cycle after reset so a level already high
    // when reset releases is not mistaken for an edge.
    edge_d     = armed_q & event_in & ~ev_q;
    push_d     = (state_q == CAPTURE);
    full_d     = (count_q == FULL_CNT);
    pop_d      = (count_q != '0) & out_if.out_ready;
    wr_en_d    = push_d & (~full_d | pop_d);
    ovf_set_d  = push_d & full_d & ~pop_d;
    // Only one edge can wait; a second one while pending is lost.
    drop_set_d = edge_d & pending_q;
    if (first_done_q) begin
      entry_d = {1'b0, timer_count - prev_ts_q};
    end
  end

  // Edge register and arming flag; reloads from event_in once out of reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples pre-edge values regardless of block ordering.
    if (reset) begin
      ev_q    <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      ev_q    <= event_in;
      armed_q <= 1'b1;
    end
  end

  // Capture FSM with registered timer_read strobe and timestamp history.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      pending_q    <= 1'b0;
      timer_read_q <= 1'b0;
      first_done_q <= 1'b0;
      prev_ts_q    <= 16'h0000;
    end else begin
      timer_read_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (edge_d || pending_q) begin
            state_q      <= READ;
            timer_read_q <= 1'b1;
            pending_q    <= 1'b0;
          end
        end
        READ: begin
          state_q <= CAPTURE;
          if (edge_d && !pending_q) pending_q <= 1'b1;
        end
        CAPTURE: begin
          state_q      <= IDLE;
          // History advances even when the FIFO write is discarded.
          prev_ts_q    <= timer_count;
          first_done_q <= 1'b1;
          if (edge_d && !pending_q) pending_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Sticky error flags; a set in the same cycle as clear_flags wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q <= 1'b0;
      dropped_q  <= 1'b0;
    end else begin
      overflow_q <= ovf_set_d  | (overflow_q & ~clear_flags);
      dropped_q  <= drop_set_d | (dropped_q  & ~clear_flags);
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en_d) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_d)   rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({wr_en_d, pop_d})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO storage.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; occupancy and
    // pointers define which entries are meaningful.
    if (wr_en_d && !reset) mem_q[wr_ptr_q] <= entry_d;
  end

  assign out_if.out_valid = (count_q != '0);
  assign out_if.out_data  = mem_q[rd_ptr_q][15:0];
  assign out_if.out_first = mem_q[rd_ptr_q][16];
  assign fill             = count_q;
  assign timer_read       = timer_read_q;
  assign overflow         = overflow_q;
  assign dropped          = dropped_q;

endmodule : event_timestamper

// File: tb/tb_event_timestamper.sv
// Directed self-checking bench for event_timestamper. Inputs are driven and
// outputs sampled on the falling clock edge.
module tb_event_timestamper;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          event_in;
  logic [15:0]   timer_count;
  logic          timer_read;
  logic [AW:0]   fill;
  logic          overflow;
  logic          dropped;
  logic          clear_flags;

  event_timestamper_if tsif ();

  event_timestamper #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .event_in    (event_in),
    .timer_count (timer_count),
    .timer_read  (timer_read),
    .fill        (fill),
    .overflow    (overflow),
    .dropped     (dropped),
    .clear_flags (clear_flags),
    .out_if      (tsif)
  );

  // 12.5 MHz clock
  always #40 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // One event: edge at cycle N, timer value held through CAPTURE (N+2),
  // optional pop during the CAPTURE cycle; returns at the N+3 sample point.
  task automatic fire(input logic [15:0] ts, input logic pop_in_capture);
    event_in    = 1'b1;
    timer_count = ts;
    tick();
    event_in    = 1'b0;
    tick();
    tsif.out_ready = pop_in_capture;
    tick();
    tsif.out_ready = 1'b0;
  endtask

  // Check the head entry, then pop it.
  task automatic pop_check(input string tag, input logic exp_first, input logic [15:0] exp_data);
    check({tag, "_valid"}, 32'(tsif.out_valid), 1);
    check({tag, "_first"}, 32'(tsif.out_first), 32'(exp_first));
    check({tag, "_data"},  32'(tsif.out_data),  32'(exp_data));
    tsif.out_ready = 1'b1;
    tick();
    tsif.out_ready = 1'b0;
  endtask

  // Watchdog: the sequence is fixed-length, this only guards against a hang.
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset          = 1'b1;
    event_in       = 1'b0;
    timer_count    = 16'h0000;
    clear_flags    = 1'b0;
    tsif.out_ready = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_fill",     32'(fill),            0);
    check("rst_valid",    32'(tsif.out_valid),  0);
    check("rst_timer_rd", 32'(timer_read),      0);
    check("rst_overflow", 32'(overflow),        0);
    check("rst_dropped",  32'(dropped),         0);
    reset = 1'b0;
    repeat (2) tick();

    // Single edge: latency and first entry
    event_in    = 1'b1;
    timer_count = 16'h0010;
    tick();                                          // N+1
    check("lat_rd_n1",    32'(timer_read),     1);
    check("lat_valid_n1", 32'(tsif.out_valid), 0);
    event_in = 1'b0;
    tick();                                          // N+2
    check("lat_rd_n2",    32'(timer_read),     0);
    check("lat_valid_n2", 32'(tsif.out_valid), 0);
    tick();                                          // N+3
    check("lat_fill_n3",  32'(fill),           1);
    pop_check("first", 1'b1, 16'h0000);
    check("first_popped_valid", 32'(tsif.out_valid), 0);
    // Pop on empty FIFO is ignored
    tsif.out_ready = 1'b1;
    tick();
    tsif.out_ready = 1'b0;
    check("empty_pop_fill", 32'(fill), 0);

    // Second edge: plain delta
    fire(16'h0035, 1'b0);
    pop_check("second", 1'b0, 16'h0025);

    // Wrap-around subtraction
    fire(16'hFFF0, 1'b0);
    pop_check("to_fff0", 1'b0, 16'hFFBB);
    fire(16'h0005, 1'b0);
    pop_check("wrap", 1'b0, 16'h0015);

    // Edges every other cycle at c=0,2,4,6. c0 captured (sample c2);
    // c2 pending (captured, sample c5); c4 in READ becomes pending
    // (sample c8); c6 arrives while still pending -> lost.
    for (int c = 0; c < 10; c++) begin
      event_in    = (c <= 6) && (c % 2 == 0);
      timer_count = 16'(16'h0100 + 16 * c);
      tick();
    end
    check("drop_flag",     32'(dropped),  1);
    check("drop_fill",     32'(fill),     3);
    check("drop_overflow", 32'(overflow), 0);
    pop_check("drop_e0", 1'b0, 16'h011B);   // 0x0120 - 0x0005
    pop_check("drop_e1", 1'b0, 16'h0030);   // 0x0150 - 0x0120
    pop_check("drop_e2", 1'b0, 16'h0030);   // 0x0180 - 0x0150
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;
    check("drop_cleared", 32'(dropped), 0);

    // Overflow: nine events with the consumer stalled
    for (int i = 0; i < 9; i++) begin
      fire(16'(16'h0200 + 16 * i), 1'b0);
    end
    check("ovf_fill",      32'(fill),           8);
    check("ovf_flag",      32'(overflow),       1);
    check("ovf_head_data", 32'(tsif.out_data),  32'h0080);   // 0x0200 - 0x0180
    check("ovf_dropped",   32'(dropped),        0);
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;
    check("ovf_cleared", 32'(overflow), 0);

    // Push while full with a simultaneous pop; delta uses the discarded
    // ninth capture (0x0280) as history.
    fire(16'h0300, 1'b1);
    check("full_pp_fill",     32'(fill),     8);
    check("full_pp_overflow", 32'(overflow), 0);
    for (int i = 1; i < 8; i++) begin
      pop_check($sformatf("drain%0d", i), 1'b0, 16'h0010);
    end
    pop_check("drain_last", 1'b0, 16'h0080);
    check("drain_valid", 32'(tsif.out_valid), 0);
    check("drain_fill",  32'(fill),           0);

    // Reset in CAPTURE aborts the write and clears the FIFO
    fire(16'h0400, 1'b0);
    check("pre_rst_fill", 32'(fill), 1);
    event_in    = 1'b1;
    timer_count = 16'h0410;
    tick();
    event_in = 1'b0;
    tick();                                          // CAPTURE cycle
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (3) tick();
    check("abort_fill",  32'(fill),           0);
    check("abort_valid", 32'(tsif.out_valid), 0);

    // event_in already high as reset releases: no edge
    event_in = 1'b1;
    reset    = 1'b1;
    tick();
    reset = 1'b0;
    repeat (4) tick();
    check("hi_at_rst_fill", 32'(fill), 0);
    event_in = 1'b0;
    tick();

    // First event after reset is flagged again
    fire(16'h0500, 1'b0);
    pop_check("post_rst", 1'b1, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_event_timestamper
